// File: rtl/demux_sel_loader.sv
// demux_sel_loader: drives the data bit and select of a registered 1-to-2**SEL_W
// demux tree. Values come either from a serial frame (data bit first, then the
// select MSB first) or from a built-in walking sweep over every select value.
// All outputs are registered, so the tree only sees clean, stable sel/in.
module demux_sel_loader #(
    parameter int SEL_W     = 9,
    parameter int SWEEP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sdi,
    input  logic             shift_en,
    input  logic             frame_clr,
    input  logic             sweep_start,
    output logic             dmx_in,
    output logic [SEL_W-1:0] dmx_sel,
    output logic             frame_done,
    output logic             sweep_done,
    output logic             busy
);

    // Frame is the data bit plus SEL_W select bits; the counter must reach SEL_W+1.
    localparam int                 CNT_W     = $clog2(SEL_W + 2);
    localparam logic [CNT_W-1:0]   FRAME_LEN = CNT_W'(SEL_W + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]         DIV_LAST  = 8'(SWEEP_DIV - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST  = '1;
    localparam logic [SEL_W-1:0]   SEL_ONE   = SEL_W'(1);

    // IDLE: no bits held. SHIFT: partial frame. APPLY: one-cycle load.
    // SWEEP: walking sweep, during which dmx_sel doubles as the sweep position.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_APPLY = 2'd2,
        ST_SWEEP = 2'd3
    } state_t;

    state_t           state;
    logic [SEL_W:0]   shreg;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       div;

    logic [SEL_W:0]   shift_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             frame_full;

    // Next shift-register contents and bit count if a bit is accepted this cycle.
    always_comb begin
        shift_next = {shreg[SEL_W-1:0], sdi};
        cnt_inc    = cnt + CNT_ONE;
        frame_full = (cnt_inc == FRAME_LEN);
    end

    // Control FSM with all outputs registered; reset drops everything to IDLE silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            div        <= '0;
            dmx_in     <= 1'b0;
            dmx_sel    <= '0;
            frame_done <= 1'b0;
            sweep_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                ST_IDLE, ST_SHIFT: begin
                    if (frame_clr) begin
                        // Discard a partial frame; the demux outputs keep their value.
                        shreg <= '0;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (shift_en) begin
                        shreg <= shift_next;
                        cnt   <= cnt_inc;
                        busy  <= 1'b1;
                        state <= frame_full ? ST_APPLY : ST_SHIFT;
                    end else if ((state == ST_IDLE) && sweep_start) begin
                        // Sweep starts at select 0 with the data bit high.
                        dmx_in  <= 1'b1;
                        dmx_sel <= '0;
                        div     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SWEEP;
                    end
                end

                ST_APPLY: begin
                    // MSB of the shift register is the first bit received: the data bit.
                    dmx_in     <= shreg[SEL_W];
                    dmx_sel    <= shreg[SEL_W-1:0];
                    frame_done <= 1'b1;
                    cnt        <= '0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end

                ST_SWEEP: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (dmx_sel == SEL_LAST) begin
                            // Last position finished: park the demux and report.
                            dmx_in     <= 1'b0;
                            dmx_sel    <= '0;
                            sweep_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            dmx_sel <= dmx_sel + SEL_ONE;
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_sel_loader.sv
// Directed testbench for demux_sel_loader (SEL_W=9, SWEEP_DIV=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_demux_sel_loader;

    logic       clk;
    logic       rst_n;
    logic       sdi;
    logic       shift_en;
    logic       frame_clr;
    logic       sweep_start;
    logic       dmx_in;
    logic [8:0] dmx_sel;
    logic       frame_done;
    logic       sweep_done;
    logic       busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    demux_sel_loader #(.SEL_W(9), .SWEEP_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sdi         (sdi),
        .shift_en    (shift_en),
        .frame_clr   (frame_clr),
        .sweep_start (sweep_start),
        .dmx_in      (dmx_in),
        .dmx_sel     (dmx_sel),
        .frame_done  (frame_done),
        .sweep_done  (sweep_done),
        .busy        (busy)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        sdi         = 1'b0;
        shift_en    = 1'b0;
        frame_clr   = 1'b0;
        sweep_start = 1'b0;
    endtask

    // Shift bits f[hi] .. f[lo] MSB first, one per clock.
    task automatic shift_bits(input logic [9:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            sdi      = f[i];
            shift_en = 1'b1;
            @(negedge clk);
        end
        shift_en = 1'b0;
        sdi      = 1'b0;
    endtask

    // After the last bit edge the FSM is in APPLY; one more edge loads the outputs.
    task automatic expect_apply(input string tag, input logic exp_in, input logic [8:0] exp_sel);
        check({tag, "_apply_pending"}, 32'({frame_done, busy}), 32'(2'b01));
        @(negedge clk);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
        check({tag, "_in"}, 32'(dmx_in), 32'(exp_in));
        check({tag, "_sel"}, 32'(dmx_sel), 32'(exp_sel));
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_frame_done_1cyc"}, 32'(frame_done), 32'd0);
    endtask

    task automatic send_frame(input string tag, input logic [9:0] f);
        shift_bits(f, 9, 0);
        expect_apply(tag, f[9], f[8:0]);
    endtask

    logic [9:0] frame_a;
    int         waited;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("reset_outputs", 32'({dmx_in, dmx_sel, frame_done, sweep_done, busy}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'({dmx_in, dmx_sel, frame_done, sweep_done, busy}), 32'd0);

        // Reset then frame: 1,1,0,0,0,0,0,1,1,1 -> in=1 sel=0x107
        frame_a = 10'b11_0000_0111;
        for (int i = 9; i >= 0; i--) begin
            sdi      = frame_a[i];
            shift_en = 1'b1;
            @(negedge clk);
            check("f1_busy_while_shifting", 32'(busy), 32'd1);
            check("f1_outputs_hold", 32'({dmx_in, dmx_sel}), 32'd0);
        end
        shift_en = 1'b0;
        expect_apply("f1", 1'b1, 9'h107);

        // Paused frame: 0 + 0x1C3, 4 bits, 20-cycle pause, 6 bits
        frame_a = {1'b0, 9'h1C3};
        shift_bits(frame_a, 9, 6);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("pause_hold", 32'({dmx_in, dmx_sel, busy, frame_done}), 32'({1'b1, 9'h107, 1'b1, 1'b0}));
        end
        shift_bits(frame_a, 5, 0);
        expect_apply("pause", 1'b0, 9'h1C3);

        // Clear mid-frame: 5 ones, clear with shift_en=1, then 0 + 0x0AA
        frame_a = 10'h3FF;
        shift_bits(frame_a, 9, 5);
        frame_clr = 1'b1;
        shift_en  = 1'b1;
        sdi       = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("clr_busy_low", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("clr_no_frame_done", 32'({frame_done, dmx_in, dmx_sel}), 32'({1'b0, 1'b0, 9'h1C3}));
        end
        send_frame("clr", {1'b0, 9'h0AA});

        // Conflict: sweep_start with shift_en in IDLE -> bit captured, no sweep
        sweep_start = 1'b1;
        shift_en    = 1'b1;
        sdi         = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("conflict_no_sweep", 32'({dmx_in, dmx_sel, busy}), 32'({1'b0, 9'h0AA, 1'b1}));
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        check("conflict_shift_ignores_sweep", 32'({dmx_in, dmx_sel, busy}), 32'({1'b0, 9'h0AA, 1'b1}));
        @(negedge clk);
        check("conflict_still_idle_out", 32'({dmx_in, dmx_sel}), 32'({1'b0, 9'h0AA}));
        frame_a = {1'b1, 9'h055};
        shift_bits(frame_a, 8, 0);
        expect_apply("conflict", 1'b1, 9'h055);

        // Full sweep with noise on the ignored inputs
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        for (int p = 0; p < 512; p++) begin
            for (int k = 0; k < 4; k++) begin
                check("sweep_step", 32'({sweep_done, frame_done, busy, dmx_in, dmx_sel}),
                      32'({1'b0, 1'b0, 1'b1, 1'b1, 9'(p)}));
                sdi         = 1'($urandom_range(0, 1));
                shift_en    = 1'($urandom_range(0, 1));
                frame_clr   = 1'($urandom_range(0, 1));
                sweep_start = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        idle_inputs();
        check("sweep_end", 32'({sweep_done, frame_done, busy, dmx_in, dmx_sel}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 9'h000}));
        @(negedge clk);
        check("sweep_done_1cyc", 32'({sweep_done, busy}), 32'd0);
        @(negedge clk);
        check("sweep_no_frame_captured", 32'({frame_done, busy, dmx_in, dmx_sel}), 32'd0);

        // Async reset mid-sweep at select 0x050
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        waited = 0;
        while (dmx_sel != 9'h050 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("reach_sel_050", 32'(dmx_sel), 32'h050);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 32'({dmx_in, dmx_sel, frame_done, sweep_done, busy}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_reset_quiet", 32'({dmx_in, dmx_sel, frame_done, sweep_done, busy}), 32'd0);
        end
        send_frame("post_reset", {1'b1, 9'h133});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
